// File: rtl/ysyx_24080006_pkg.sv
// Shared core-wide constants.
package ysyx_24080006_pkg;
    // GPR index width (32 architectural registers)
    localparam int RegWidth = 5;
endpackage

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: per-port one-entry writeback buffers drained
// round-robin into a single registered regfile write port, plus a
// pending-write lookup so issue logic can stall reads that would see stale data.
module gpr_wb_arbiter #(
    parameter int NumPorts = 3,
    parameter int RegWidth = ysyx_24080006_pkg::RegWidth
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NumPorts-1:0]                wb_valid,
    output logic [NumPorts-1:0]                wb_ready,
    input  logic [NumPorts-1:0][RegWidth-1:0]  wb_addr,
    input  logic [NumPorts-1:0][31:0]          wb_data,
    output logic                               gpr_we,
    output logic [RegWidth-1:0]                gpr_waddr,
    output logic [31:0]                        gpr_wdata,
    input  logic [RegWidth-1:0]                chk_addr_1,
    input  logic [RegWidth-1:0]                chk_addr_2,
    output logic                               chk_busy_1,
    output logic                               chk_busy_2
);

    localparam int PtrW = $clog2(NumPorts);

    typedef struct packed {
        logic [RegWidth-1:0] addr;
        logic [31:0]         data;
    } wb_ent_t;

    logic    [NumPorts-1:0] buf_valid;
    wb_ent_t [NumPorts-1:0] buf_q;
    logic    [PtrW-1:0]     rr_ptr;
    logic    [NumPorts-1:0] grant;
    logic                   gnt_any;
    logic    [PtrW-1:0]     gnt_idx;
    logic    [NumPorts-1:0] load;

    // Round-robin search: first valid buffer at or after rr_ptr, wrapping
    always_comb begin
        int j;
        j       = 0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NumPorts; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NumPorts) j = j - NumPorts;
            if (!gnt_any && buf_valid[PtrW'(j)]) begin
                gnt_any            = 1'b1;
                gnt_idx            = PtrW'(j);
                grant[PtrW'(j)]    = 1'b1;
            end
        end
    end

    // A draining buffer can be refilled in the same cycle
    assign wb_ready = ~buf_valid | grant;

    // x0 writes are acknowledged but never buffered
    for (genvar k = 0; k < NumPorts; k++) begin : g_load
        assign load[k] = wb_valid[k] & wb_ready[k] & (wb_addr[k] != '0);
    end

    // Per-port buffers: refill wins over drain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_valid <= '0;
            buf_q     <= '0;
        end else begin
            for (int k = 0; k < NumPorts; k++) begin
                if (load[k]) begin
                    buf_valid[k] <= 1'b1;
                    buf_q[k]     <= '{addr: wb_addr[k], data: wb_data[k]};
                end else if (grant[k]) begin
                    buf_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Registered write port and round-robin pointer advance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gpr_we    <= 1'b0;
            gpr_waddr <= '0;
            gpr_wdata <= '0;
            rr_ptr    <= '0;
        end else begin
            gpr_we <= gnt_any;
            if (gnt_any) begin
                gpr_waddr <= buf_q[gnt_idx].addr;
                gpr_wdata <= buf_q[gnt_idx].data;
                rr_ptr    <= (gnt_idx == PtrW'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Pending-write lookup over buffers and the output register only
    always_comb begin
        chk_busy_1 = gpr_we && (gpr_waddr == chk_addr_1);
        chk_busy_2 = gpr_we && (gpr_waddr == chk_addr_2);
        for (int k = 0; k < NumPorts; k++) begin
            chk_busy_1 = chk_busy_1 | (buf_valid[k] && (buf_q[k].addr == chk_addr_1));
            chk_busy_2 = chk_busy_2 | (buf_valid[k] && (buf_q[k].addr == chk_addr_2));
        end
        chk_busy_1 = chk_busy_1 && (chk_addr_1 != '0);
        chk_busy_2 = chk_busy_2 && (chk_addr_2 != '0);
    end

endmodule
